// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, FU select codes, FSM states and instruction field positions
package ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_RSV6 = 4'h6;
  localparam logic [3:0] OP_RSV7 = 4'h7;
  localparam logic [3:0] OP_ADI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BN   = 4'hD;
  localparam logic [3:0] OP_JAL  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [3:0] SEL_PASS_A = 4'b0000;
  localparam logic [3:0] SEL_ADD    = 4'b0010;
  localparam logic [3:0] SEL_SUB    = 4'b0101;
  localparam logic [3:0] SEL_AND    = 4'b1000;
  localparam logic [3:0] SEL_OR     = 4'b1010;
  localparam logic [3:0] SEL_XOR    = 4'b1100;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int DA_HI  = 27;
  localparam int DA_LO  = 23;
  localparam int AA_HI  = 22;
  localparam int AA_LO  = 18;
  localparam int BA_HI  = 17;
  localparam int BA_LO  = 13;
  localparam int IMM_HI = 12;
  localparam int IMM_LO = 0;
  localparam int IMM_W  = IMM_HI - IMM_LO + 1;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational IR decode into datapath selects, addresses and immediate
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int SIZE = 32,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic [SIZE-1:0] ir,
  output logic            MuxB_sel,
  output logic            MuxD_sel,
  output logic            MuxR_sel,
  output logic [3:0]      Sel,
  output logic [AW-1:0]   AA,
  output logic [AW-1:0]   BA,
  output logic [AW-1:0]   DA,
  output logic [SIZE-1:0] Constant_out,
  output logic            exec_we
);

  logic [3:0] opcode;

  assign opcode       = ir[OP_HI:OP_LO];
  assign DA           = ir[DA_HI:DA_LO];
  assign AA           = ir[AA_HI:AA_LO];
  assign BA           = ir[BA_HI:BA_LO];
  assign Constant_out = {{(SIZE-IMM_W){ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};

  // exec_we covers only the EXEC-cycle writes; the LD write is timed by dmem_ack upstream
  always_comb begin
    Sel      = SEL_PASS_A;
    MuxB_sel = 1'b0;
    MuxD_sel = 1'b0;
    MuxR_sel = 1'b0;
    exec_we  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        MuxD_sel = 1'b1;
        MuxR_sel = 1'b1;
        exec_we  = 1'b1;
        case (opcode)
          OP_ADD:  Sel = SEL_ADD;
          OP_SUB:  Sel = SEL_SUB;
          OP_AND:  Sel = SEL_AND;
          OP_OR:   Sel = SEL_OR;
          default: Sel = SEL_XOR;
        endcase
      end
      OP_ADI: begin
        Sel      = SEL_ADD;
        MuxB_sel = 1'b1;
        MuxD_sel = 1'b1;
        MuxR_sel = 1'b1;
        exec_we  = 1'b1;
      end
      OP_LD: begin
        Sel      = SEL_ADD;
        MuxB_sel = 1'b1;
        MuxR_sel = 1'b1;
      end
      OP_ST: begin
        Sel      = SEL_ADD;
        MuxB_sel = 1'b1;
      end
      OP_JAL: begin
        exec_we  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/exec/mem sequencer owning PC and IR; ILLEGAL_TRAP_EN traps opcodes 6/7
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int              SIZE     = 32,
  parameter logic [SIZE-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [SIZE-1:0]          imem_addr,
  input  logic                     imem_ack,
  input  logic [SIZE-1:0]          imem_data,
  output logic                     dmem_req,
  output logic                     dmem_we,
  input  logic                     dmem_ack,
  input  logic [SIZE-1:0]          addr_in,
  input  logic                     Z,
  input  logic                     N,
  input  logic                     C,
  input  logic                     V,
  output logic                     we,
  output logic                     MuxB_sel,
  output logic                     MuxD_sel,
  output logic                     MuxR_sel,
  output logic [3:0]               Sel,
  output logic [$clog2(SIZE)-1:0]  AA,
  output logic [$clog2(SIZE)-1:0]  BA,
  output logic [$clog2(SIZE)-1:0]  DA,
  output logic [SIZE-1:0]          Constant_out,
  output logic [SIZE-1:0]          PC_out,
`ifdef ILLEGAL_TRAP_EN
  output logic                     illegal,
`endif
  output logic                     halted
);

  state_t          state;
  logic [SIZE-1:0] pc;
  logic [SIZE-1:0] ir;
  logic [SIZE-1:0] pc_inc;
  logic [SIZE-1:0] pc_rel;
  logic [3:0]      opcode;
  logic            exec_we;
  logic            unused_flags;

  instr_decoder #(.SIZE(SIZE)) u_dec (
    .ir           (ir),
    .MuxB_sel     (MuxB_sel),
    .MuxD_sel     (MuxD_sel),
    .MuxR_sel     (MuxR_sel),
    .Sel          (Sel),
    .AA           (AA),
    .BA           (BA),
    .DA           (DA),
    .Constant_out (Constant_out),
    .exec_we      (exec_we)
  );

  assign opcode       = ir[OP_HI:OP_LO];
  assign pc_inc       = pc + SIZE'(1);
  assign pc_rel       = pc + Constant_out;
  assign imem_addr    = pc;
  assign PC_out       = pc_inc;
  assign halted       = (state == ST_HALT);
  assign dmem_we      = dmem_req && (opcode == OP_ST);
  assign unused_flags = C ^ V;

  // LD writes back only in the cycle its data arrives
  assign we = ((state == ST_EXEC) && exec_we) ||
              ((state == ST_MEM) && dmem_req && dmem_ack && (opcode == OP_LD));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
          case (opcode)
            OP_LD, OP_ST: begin
              state    <= ST_MEM;
              imem_req <= 1'b0;
              dmem_req <= 1'b1;
            end
            OP_JMP: pc <= addr_in;
            OP_BZ:  pc <= Z ? pc_rel : pc_inc;
            OP_BN:  pc <= N ? pc_rel : pc_inc;
            OP_JAL: pc <= pc_rel;
            OP_HLT: begin
              state    <= ST_HALT;
              imem_req <= 1'b0;
            end
`ifdef ILLEGAL_TRAP_EN
            OP_RSV6, OP_RSV7: begin
              state    <= ST_HALT;
              imem_req <= 1'b0;
              illegal  <= 1'b1;
            end
`endif
            default: pc <= pc_inc;
          endcase
        end
        ST_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            pc       <= pc_inc;
            imem_req <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench: expected fetch addresses queued per executed instruction
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_data = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] addr_in = '0;
  logic        Z = 1'b0, N = 1'b0, C = 1'b0, V = 1'b0;
  logic        we, MuxB_sel, MuxD_sel, MuxR_sel;
  logic [3:0]  Sel;
  logic [4:0]  AA, BA, DA;
  logic [31:0] Constant_out, PC_out;
  logic        halted;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] fetch_q[$];
  logic [31:0] cur_pc;

  always #5 clk = ~clk;

  control_sequencer #(.SIZE(32), .RESET_PC(32'd0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .addr_in(addr_in), .Z(Z), .N(N), .C(C), .V(V),
    .we(we), .MuxB_sel(MuxB_sel), .MuxD_sel(MuxD_sel), .MuxR_sel(MuxR_sel), .Sel(Sel),
    .AA(AA), .BA(BA), .DA(DA), .Constant_out(Constant_out), .PC_out(PC_out),
`ifdef ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .halted(halted)
  );

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] da,
                                      input logic [4:0] aa, input logic [4:0] ba,
                                      input logic [12:0] imm);
    return {op, da, aa, ba, imm};
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic z, input logic n,
                                             input logic [31:0] tgt);
    logic [31:0] simm;
    simm = {{19{ins[12]}}, ins[12:0]};
    case (ins[31:28])
      4'hB:    return tgt;
      4'hC:    return z ? pc + simm : pc + 32'd1;
      4'hD:    return n ? pc + simm : pc + 32'd1;
      4'hE:    return pc + simm;
      default: return pc + 32'd1;
    endcase
  endfunction

  task automatic fetch(input logic [31:0] ins, input int delay, input string name);
    logic [31:0] exp_addr;
    int t;
    exp_addr = (fetch_q.size() != 0) ? fetch_q.pop_front() : 32'hDEAD_BEEF;
    t = 0;
    while (imem_req !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    total_cnt++;
    if (imem_req !== 1'b1) begin
      $display("FAIL %s_fetch_timeout imem_req=%b expected 1", name, imem_req);
      return;
    end else pass_cnt++;
    total_cnt++;
    if (imem_addr !== exp_addr) $display("FAIL %s_fetch_addr got %h expected %h", name, imem_addr, exp_addr);
    else pass_cnt++;
    cur_pc = exp_addr;
    repeat (delay) @(negedge clk);
    imem_ack  = 1'b1;
    imem_data = ins;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = '0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if ({imem_req, dmem_req, we, halted} !== 4'b0) $display("FAIL reset_outputs got %b expected 0000", {imem_req, dmem_req, we, halted});
    else pass_cnt++;
    total_cnt++;
    if ({Sel, MuxB_sel, MuxD_sel, MuxR_sel} !== 7'b0) $display("FAIL reset_selects got %b expected 0", {Sel, MuxB_sel, MuxD_sel, MuxR_sel});
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) $display("FAIL reset_first_req req=%b addr=%h expected 1/0", imem_req, imem_addr);
    else pass_cnt++;
    fetch_q.push_back(32'd0);
  endtask

  task automatic test_alu(input logic [31:0] ins, input logic [3:0] exp_sel,
                          input logic exp_muxb, input string name);
    fetch(ins, 1, name);
    total_cnt++;
    if ({we, Sel, MuxB_sel, MuxD_sel, MuxR_sel} !== {1'b1, exp_sel, exp_muxb, 2'b11})
      $display("FAIL %s_ctrl got %b expected %b", name, {we, Sel, MuxB_sel, MuxD_sel, MuxR_sel}, {1'b1, exp_sel, exp_muxb, 2'b11});
    else pass_cnt++;
    total_cnt++;
    if (Constant_out !== {{19{ins[12]}}, ins[12:0]} || DA !== ins[27:23] || AA !== ins[22:18] || BA !== ins[17:13])
      $display("FAIL %s_fields const=%h DA=%0d AA=%0d BA=%0d", name, Constant_out, DA, AA, BA);
    else pass_cnt++;
    fetch_q.push_back(model_next(cur_pc, ins, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    #1;
    total_cnt++;
    if (we !== 1'b0) $display("FAIL %s_we_pulse got %b expected 0", name, we);
    else pass_cnt++;
  endtask

  task automatic test_load_store(input logic store, input int ack_delay, input string name);
    logic [31:0] ins;
    int req_cycles;
    logic we_early;
    ins = enc(store ? 4'hA : 4'h9, 5'd3, 5'd1, 5'd2, 13'd7);
    fetch(ins, 0, name);
    total_cnt++;
    if (we !== 1'b0 || Sel !== 4'b0010 || MuxB_sel !== 1'b1) $display("FAIL %s_exec we=%b Sel=%b MuxB=%b expected 0/0010/1", name, we, Sel, MuxB_sel);
    else pass_cnt++;
    req_cycles = 0;
    we_early = 1'b0;
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      #1;
      if (dmem_req === 1'b1) req_cycles++;
      if (we !== 1'b0) we_early = 1'b1;
    end
    @(negedge clk);
    dmem_ack = 1'b1;
    #1;
    if (dmem_req === 1'b1) req_cycles++;
    total_cnt++;
    if (we_early !== 1'b0) $display("FAIL %s_we_before_ack got 1 expected 0", name);
    else pass_cnt++;
    total_cnt++;
    if (dmem_we !== store) $display("FAIL %s_dmem_we got %b expected %b", name, dmem_we, store);
    else pass_cnt++;
    total_cnt++;
    if (store && we !== 1'b0) $display("FAIL %s_ack_we got %b expected 0", name, we);
    else if (!store && {we, MuxD_sel, MuxR_sel} !== 3'b101) $display("FAIL %s_ack_ctrl got %b expected 101", name, {we, MuxD_sel, MuxR_sel});
    else pass_cnt++;
    fetch_q.push_back(model_next(cur_pc, ins, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    total_cnt++;
    if (dmem_req !== 1'b0 || req_cycles != ack_delay + 1) $display("FAIL %s_req_len req=%b cycles=%0d expected 0/%0d", name, dmem_req, req_cycles, ack_delay + 1);
    else pass_cnt++;
  endtask

  task automatic test_jal();
    logic [31:0] ins;
    ins = enc(4'hE, 5'd31, 5'd0, 5'd0, 13'd16);
    fetch(ins, 0, "jal");
    total_cnt++;
    if (PC_out !== cur_pc + 32'd1 || MuxR_sel !== 1'b0 || we !== 1'b1) $display("FAIL jal_ctrl PC_out=%h MuxR=%b we=%b expected %h/0/1", PC_out, MuxR_sel, we, cur_pc + 32'd1);
    else pass_cnt++;
    fetch_q.push_back(model_next(cur_pc, ins, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
  endtask

  task automatic test_flow(input logic [31:0] ins, input logic z, input logic n,
                           input logic [31:0] tgt, input string name);
    fetch(ins, 0, name);
    Z = z;
    N = n;
    addr_in = tgt;
    #1;
    total_cnt++;
    if (we !== 1'b0 || (ins[31:28] != 4'h0 && Sel !== 4'b0000)) $display("FAIL %s_exec we=%b Sel=%b expected 0/0000", name, we, Sel);
    else pass_cnt++;
    fetch_q.push_back(model_next(cur_pc, ins, z, n, tgt));
    @(negedge clk);
    Z = 1'b0;
    N = 1'b0;
    addr_in = '0;
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] exp_addr;
    int t;
    exp_addr = fetch_q.pop_front();
    t = 0;
    while (imem_req !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr) $display("FAIL rstf_held req=%b addr=%h expected 1/%h", imem_req, imem_addr, exp_addr);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++;
    if (imem_req !== 1'b0 || dmem_req !== 1'b0) $display("FAIL rstf_cleared req=%b dreq=%b expected 0/0", imem_req, dmem_req);
    else pass_cnt++;
    reset = 1'b1;
    fetch_q.delete();
    fetch_q.push_back(32'd0);
  endtask

  task automatic test_reset_mid_mem();
    fetch(enc(4'h9, 5'd1, 5'd0, 5'd0, 13'd0), 0, "rstm");
    @(negedge clk);
    #1;
    total_cnt++;
    if (dmem_req !== 1'b1) $display("FAIL rstm_mem_req got %b expected 1", dmem_req);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++;
    if (imem_req !== 1'b0 || dmem_req !== 1'b0 || we !== 1'b0) $display("FAIL rstm_cleared req=%b dreq=%b we=%b expected 000", imem_req, dmem_req, we);
    else pass_cnt++;
    reset = 1'b1;
    fetch_q.delete();
    fetch_q.push_back(32'd0);
  endtask

  task automatic test_halt();
    logic stray;
    fetch(enc(4'hF, 5'd0, 5'd0, 5'd0, 13'd0), 0, "hlt");
    stray = 1'b0;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || we !== 1'b0) stray = 1'b1;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    total_cnt++;
    if (halted !== 1'b1 || stray !== 1'b0) $display("FAIL hlt_state halted=%b stray=%b expected 1/0", halted, stray);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total_cnt++;
    if (halted !== 1'b0) $display("FAIL hlt_reset_exit halted=%b expected 0", halted);
    else pass_cnt++;
    fetch_q.delete();
    fetch_q.push_back(32'd0);
  endtask

  task automatic test_reserved();
    fetch(enc(4'h6, 5'd1, 5'd1, 5'd1, 13'd0), 0, "rsv");
    total_cnt++;
    if (we !== 1'b0) $display("FAIL rsv_we got %b expected 0", we);
    else pass_cnt++;
    @(negedge clk);
    #1;
`ifdef ILLEGAL_TRAP_EN
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if ({halted, illegal, imem_req} !== 3'b110 || imem_addr !== cur_pc) $display("FAIL rsv_trap h/i/req=%b addr=%h expected 110/%h", {halted, illegal, imem_req}, imem_addr, cur_pc);
    else pass_cnt++;
`else
    total_cnt++;
    if (halted !== 1'b0) $display("FAIL rsv_nop_halted got %b expected 0", halted);
    else pass_cnt++;
    fetch_q.push_back(model_next(cur_pc, enc(4'h6, 5'd1, 5'd1, 5'd1, 13'd0), 1'b0, 1'b0, 32'd0));
    fetch(enc(4'h0, 5'd0, 5'd0, 5'd0, 13'd0), 0, "rsv_next");
`endif
  endtask

  initial begin
    test_reset();
    test_alu(enc(4'h8, 5'd1, 5'd0, 5'd0, 13'd5), 4'b0010, 1'b1, "adi");       // pc 0
    test_alu(enc(4'h8, 5'd4, 5'd2, 5'd0, 13'h1FFF), 4'b0010, 1'b1, "adi_neg"); // pc 1
    test_alu(enc(4'h2, 5'd2, 5'd1, 5'd1, 13'd0), 4'b0101, 1'b0, "sub");       // pc 2
    test_load_store(1'b0, 3, "ld");                                             // pc 3
    test_jal();                                                                 // pc 4 -> 20
    test_load_store(1'b1, 0, "st");                                             // pc 20
    test_flow(enc(4'hB, 5'd0, 5'd3, 5'd0, 13'd0), 1'b0, 1'b0, 32'd10, "jmp");    // pc 21 -> 10
    test_flow(enc(4'hC, 5'd0, 5'd1, 5'd0, 13'h1FFE), 1'b1, 1'b0, 32'd0, "bz_t"); // pc 10 -> 8
    test_flow(enc(4'h0, 5'd0, 5'd0, 5'd0, 13'd0), 1'b0, 1'b0, 32'd0, "nop8");
    test_flow(enc(4'h0, 5'd0, 5'd0, 5'd0, 13'd0), 1'b0, 1'b0, 32'd0, "nop9");
    test_flow(enc(4'hC, 5'd0, 5'd1, 5'd0, 13'h1FFE), 1'b0, 1'b1, 32'd0, "bz_nt"); // pc 10 -> 11
    test_flow(enc(4'hD, 5'd0, 5'd1, 5'd0, 13'd3), 1'b0, 1'b1, 32'd0, "bn_t");     // pc 11 -> 14
    test_flow(enc(4'hB, 5'd0, 5'd1, 5'd0, 13'd0), 1'b0, 1'b0, 32'hFFFF_FFFF, "jmp_top");
    test_flow(enc(4'h0, 5'd0, 5'd0, 5'd0, 13'd0), 1'b0, 1'b0, 32'd0, "wrap");     // 0xFFFFFFFF -> 0
    test_reset_mid_fetch();
    test_reset_mid_mem();
    test_halt();
    test_reserved();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle instruction sequencer sitting directly upstream of the 32-register datapath.
- Owns the PC and the instruction register (IR).
- Fetches instructions over a req/ack instruction-memory port and decodes them into the datapath control fields (we, MuxB_sel, MuxD_sel, MuxR_sel, Sel, AA, BA, DA, constant, PC).
- Sequences data-memory handshakes for loads and stores, and resolves branches from the datapath's combinational flags.

Parameters:
- SIZE, 32, data/instruction/PC width; register-address width is $clog2(SIZE).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  SIZE  fetch address; equals PC.
- imem_ack  in  1  fetch data valid.
- imem_data  in  SIZE  instruction word.
- dmem_req  out  1  data access request; address/data come from datapath Addr_out/Data_out.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_ack  in  1  data access complete; load data goes straight to datapath Data_in.
- addr_in  in  SIZE  datapath Addr_out (FU result), used for JMP target.
- Z, N, C, V  in  1 each  datapath flags (combinational, current cycle).
- we  out  1  register-file write enable.
- MuxB_sel, MuxD_sel, MuxR_sel  out  1 each  datapath mux selects.
- Sel  out  4  FU function.
- AA, BA, DA  out  $clog2(SIZE) each  register addresses.
- Constant_out  out  SIZE  sign-extended immediate.
- PC_out  out  SIZE  PC+1 (JAL link value into datapath PC_in).
- halted  out  1  sequencer stopped.

Behaviour:
- Instruction format:
  - [31:28] opcode, [27:23] DA, [22:18] AA, [17:13] BA, [12:0] immediate.
  - Constant_out = imm sign-extended to SIZE.
- Opcodes:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR; 6,7 reserved.
  - 8 ADI; 9 LD; A ST; B JMP; C BZ; D BN; E JAL; F HLT.
- FSM states: FETCH, EXEC, MEM, HALT.
- Reset (reset=0 at a clk edge, from any state, including mid-handshake):
  - State FETCH, PC=RESET_PC, IR=0.
  - imem_req=0, dmem_req=0, we=0, halted=0; all selects and Sel=0.
  - imem_req rises the cycle after reset deasserts.
- FETCH:
  - imem_req=1, imem_addr=PC, held stable until imem_ack.
  - On ack: IR<=imem_data, go to EXEC.
  - A minimum fetch takes 2 cycles (req cycle, ack same cycle → EXEC next).
- EXEC: one cycle; AA/BA/DA/Sel/mux selects are driven from IR.
- ALU ops (ADD/SUB/AND/OR/XOR):
  - MuxB=0, MuxD=1, MuxR=1, we=1.
  - PC<=PC+1, go to FETCH.
- ADI: as ALU ops with Sel=ADD, MuxB=1.
- LD: Sel=ADD, MuxB=1 (addr = R[AA]+imm); go to MEM.
- ST: same address computation as LD; go to MEM.
- MEM:
  - Controls are held from EXEC.
  - dmem_req=1; dmem_we=1 for ST, 0 for LD.
  - LD: on dmem_ack, we=1, MuxD=0, MuxR=1 in that cycle.
  - On ack: PC<=PC+1, go to FETCH.
  - The request is held indefinitely until ack.
- JMP: Sel=PASS_A; PC<=addr_in.
- BZ / BN:
  - Sel=PASS_A on R[AA].
  - If Z (resp. N) =1, PC<=PC+imm; else PC<=PC+1.
- JAL: MuxR=0, we=1, R[DA]<=PC+1, PC<=PC+imm.
- NOP: PC<=PC+1.
- Reserved opcodes: treated as NOP.
- HLT: go to HALT; halted=1, all requests 0, we=0. Only reset exits.
- PC arithmetic is modulo 2^SIZE and wraps silently.
- we is never asserted outside the EXEC/MEM cycles above.
- imem_ack and dmem_ack are ignored when the matching req is 0.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: opcodes 6/7 in EXEC go to HALT with halted=1 and an extra output illegal=1 (sticky until reset). PC is left pointing at the offending instruction.
- Undefined: no illegal port; reserved opcodes behave as NOP.

Decomposition:
- Package ctrl_pkg: opcode localparams, FSM state encoding, instruction field bit positions.
- ctrl_pkg FU Sel constants: PASS_A=4'b0000, ADD=4'b0010, SUB=4'b0101, AND=4'b1000, OR=4'b1010, XOR=4'b1100.
- Sub-module instr_decoder: combinational IR → selects/Sel/addresses/Constant_out. The FSM and PC stay in control_sequencer.

Test Plan:
- Reset with RESET_PC=0; imem returns ADI DA=1 AA=0 imm=5 with 1-cycle ack delay → we pulses 1 cycle, Sel=0010, MuxB=1, Constant_out=5, DA=1; next imem_addr=1.
- ADI imm=0x1FFF → Constant_out=0xFFFFFFFF; SUB DA=2 AA=1 BA=1 → Sel=0101, MuxB=0, we=1.
- LD with dmem_ack delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, we=1 only in the ack cycle with MuxD=0; ST → dmem_we=1, we never 1.
- BZ imm=-2 at PC=10: Z=1 → next imem_addr=8; Z=0 → 11. JAL at PC=4 imm=16 → PC_out=5, MuxR=0, we=1, next fetch 20.
- Assert reset during a held imem_req and during MEM → next cycle imem_req=0, dmem_req=0, then fetch from 0.
- HLT → halted=1, no further req; opcode 6 → NOP without ILLEGAL_TRAP_EN, halted=1 and illegal=1 with it.
